// File: rtl/octree_fifo_reader.sv
// Read master for a registered-output FIFO, 2-entry skid buffer, valid/ready out.
// Ports: clk, rst, fifo_empty/fifo_rd_en/fifo_rdata, flush, m_valid/m_ready/m_data, busy, rd_cnt (OCTREE_FIFO_RD_CNT_EN).
module octree_fifo_reader #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  busy
`ifdef OCTREE_FIFO_RD_CNT_EN
  ,
  output logic [31:0]           rd_cnt
`endif
);

  logic [DATA_WIDTH-1:0] mem_q [2];
  logic [1:0] occ;
  logic       inflight;
  logic       drop;
  logic       wr_idx;
  logic       rd_idx;

  logic       pop;
  logic       push;
  logic [1:0] level;

  // Slots committed once this cycle settles; a read is only
  // issued when its word is sure to find a free slot.
  always_comb begin
    pop        = m_valid && m_ready;
    push       = inflight && !drop && !flush;
    level      = occ + {1'b0, inflight} - {1'b0, pop};
    fifo_rd_en = !fifo_empty && !flush && !rst && (level <= 2'd1);
  end

  assign m_valid = (occ != 2'd0);
  assign m_data  = mem_q[rd_idx];
  assign busy    = (occ != 2'd0) || inflight;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      drop     <= 1'b0;
      wr_idx   <= 1'b0;
      rd_idx   <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      inflight <= fifo_rd_en;
      // Marks a word caught in flight by a flush; it is a
      // one-cycle guard since no read is issued while flushing.
      drop     <= flush && inflight;
      if (flush) begin
        occ    <= 2'd0;
        wr_idx <= 1'b0;
        rd_idx <= 1'b0;
      end else begin
        if (push) begin
          mem_q[wr_idx] <= fifo_rdata;
          wr_idx        <= ~wr_idx;
        end
        if (pop) begin
          rd_idx <= ~rd_idx;
        end
        occ <= occ + {1'b0, push} - {1'b0, pop};
      end
    end
  end

`ifdef OCTREE_FIFO_RD_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt <= 32'd0;
    end else if (pop) begin
      rd_cnt <= rd_cnt + 32'd1;
    end
  end
`endif

  a_occ_ovf: assert property (
    @(posedge clk) disable iff (rst)
    !(push && !pop && occ == 2'd2)
  );

endmodule
